// File: rtl/stride_vp_pkg.sv
// Shared types and helpers for the stride value predictor.
// Widths are passed in so one package serves any parameter set.
package stride_vp_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] last;
    logic [31:0] stride;
    logic [31:0] conf;
  } entry_t;

  function automatic logic [31:0] width_mask(
    input int w
  );
    return (w >= 32) ? 32'hffff_ffff
                     : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] get_index(
    input logic [31:0] pc,
    input int          iw
  );
    return (pc >> 2) & width_mask(iw);
  endfunction

  function automatic logic [31:0] get_tag(
    input logic [31:0] pc,
    input int          iw,
    input int          tw
  );
    return (pc >> (iw + 2)) & width_mask(tw);
  endfunction

  function automatic logic [31:0] sext_stride(
    input logic [31:0] s,
    input int          w
  );
    int sh;
    sh = 32 - w;
    return $signed(s << sh) >>> sh;
  endfunction

  function automatic logic stride_fits(
    input logic [31:0] d,
    input int          w
  );
    return sext_stride(d, w) == d;
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] c,
    input int          w
  );
    return (c == width_mask(w)) ? c : c + 32'h1;
  endfunction

  function automatic logic conf_msb(
    input logic [31:0] c,
    input int          w
  );
    return ((c >> (w - 1)) & 32'h1) != 32'h0;
  endfunction

endpackage

// File: rtl/stride_vp_conflict.sv
// Same-index feedback arbitration: highest lane writes and
// its match is merged with every lower lane on that index.
module stride_vp_conflict #(
  parameter int P_NUM_PRED    = 2,
  parameter int P_INDEX_WIDTH = 11
) (
  input  logic [P_NUM_PRED-1:0]                    valid_i,
  input  logic [P_NUM_PRED-1:0][P_INDEX_WIDTH-1:0] idx_i,
  input  logic [P_NUM_PRED-1:0]                    match_i,
  output logic [P_NUM_PRED-1:0]                    we_o,
  output logic [P_NUM_PRED-1:0]                    all_match_o
);

  always_comb begin
    we_o        = '0;
    all_match_o = '0;
    for (int l = 0; l < P_NUM_PRED; l++) begin
      we_o[l]        = valid_i[l];
      all_match_o[l] = match_i[l];
      for (int j = 0; j < P_NUM_PRED; j++) begin
        if (valid_i[j] && idx_i[j] == idx_i[l]) begin
          if (j > l)
            we_o[l] = 1'b0;
          if (j < l && !match_i[j])
            all_match_o[l] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/stride_vp_top.sv
// Tagged stride value predictor: predicts last + stride per PC,
// confidence counts consecutive stride repeats.
module stride_vp_top
  import stride_vp_pkg::*;
#(
  parameter int P_STORAGE_SIZE = 2048,
  parameter int P_CONF_WIDTH   = 8,
  parameter int P_NUM_PRED     = 2,
  parameter int P_TAG_WIDTH    = 8,
  parameter int P_STRIDE_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [P_NUM_PRED-1:0][31:0]  fw_pc_i,
  input  logic [P_NUM_PRED-1:0]        fw_valid_i,
  output logic [P_NUM_PRED-1:0][31:0]  pred_pc_o,
  output logic [P_NUM_PRED-1:0][31:0]  pred_result_o,
  output logic [P_NUM_PRED-1:0]        pred_conf_o,
  output logic [P_NUM_PRED-1:0]        pred_valid_o,
  input  logic [P_NUM_PRED-1:0][31:0]  fb_pc_i,
  input  logic [P_NUM_PRED-1:0][31:0]  fb_actual_i,
  input  logic [P_NUM_PRED-1:0]        fb_valid_i
);

  localparam int P_INDEX_WIDTH = $clog2(P_STORAGE_SIZE);
  localparam int IW = P_INDEX_WIDTH;
  localparam int TW = P_TAG_WIDTH;
  localparam int SW = P_STRIDE_WIDTH;
  localparam int CW = P_CONF_WIDTH;

  logic [P_STORAGE_SIZE-1:0] valid_q;
  logic [TW-1:0]             tag_q    [P_STORAGE_SIZE];
  logic [31:0]               last_q   [P_STORAGE_SIZE];
  logic [SW-1:0]             stride_q [P_STORAGE_SIZE];
  logic [CW-1:0]             conf_q   [P_STORAGE_SIZE];

  logic [P_NUM_PRED-1:0][IW-1:0] fw_idx;
  logic [P_NUM_PRED-1:0][TW-1:0] fw_tag;
  entry_t [P_NUM_PRED-1:0]       fw_ent;
  logic [P_NUM_PRED-1:0]         fw_hit;
  logic [P_NUM_PRED-1:0]         fw_conf;
  logic [P_NUM_PRED-1:0][31:0]   fw_res;

  logic [P_NUM_PRED-1:0][IW-1:0] fb_idx;
  logic [P_NUM_PRED-1:0][TW-1:0] fb_tag;
  entry_t [P_NUM_PRED-1:0]       fb_ent;
  logic [P_NUM_PRED-1:0]         fb_hit;
  logic [P_NUM_PRED-1:0]         fb_match;
  logic [P_NUM_PRED-1:0][31:0]   fb_d;
  logic [P_NUM_PRED-1:0]         fb_we;
  logic [P_NUM_PRED-1:0]         fb_all_match;
  logic [P_NUM_PRED-1:0][SW-1:0] nw_stride;
  logic [P_NUM_PRED-1:0][CW-1:0] nw_conf;

  always_comb begin
    fw_idx  = '0;
    fw_tag  = '0;
    fw_ent  = '0;
    fw_hit  = '0;
    fw_conf = '0;
    fw_res  = '0;
    for (int l = 0; l < P_NUM_PRED; l++) begin
      fw_idx[l] = IW'(get_index(fw_pc_i[l], IW));
      fw_tag[l] = TW'(get_tag(fw_pc_i[l], IW, TW));
      fw_ent[l].valid  = valid_q[fw_idx[l]];
      fw_ent[l].tag    = 32'(tag_q[fw_idx[l]]);
      fw_ent[l].last   = last_q[fw_idx[l]];
      fw_ent[l].stride =
        sext_stride(32'(stride_q[fw_idx[l]]), SW);
      fw_ent[l].conf   = 32'(conf_q[fw_idx[l]]);
      fw_hit[l] = fw_ent[l].valid &&
                  fw_ent[l].tag == 32'(fw_tag[l]);
      if (fw_hit[l]) begin
        fw_res[l]  = fw_ent[l].last + fw_ent[l].stride;
        fw_conf[l] = conf_msb(fw_ent[l].conf, CW);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_valid_o  <= '0;
      pred_conf_o   <= '0;
      pred_result_o <= '0;
      pred_pc_o     <= '0;
    end else begin
      pred_valid_o  <= fw_valid_i;
      pred_conf_o   <= fw_conf;
      pred_result_o <= fw_res;
      pred_pc_o     <= fw_pc_i;
    end
  end

  always_comb begin
    fb_idx   = '0;
    fb_tag   = '0;
    fb_ent   = '0;
    fb_hit   = '0;
    fb_match = '0;
    fb_d     = '0;
    for (int l = 0; l < P_NUM_PRED; l++) begin
      fb_idx[l] = IW'(get_index(fb_pc_i[l], IW));
      fb_tag[l] = TW'(get_tag(fb_pc_i[l], IW, TW));
      fb_ent[l].valid  = valid_q[fb_idx[l]];
      fb_ent[l].tag    = 32'(tag_q[fb_idx[l]]);
      fb_ent[l].last   = last_q[fb_idx[l]];
      fb_ent[l].stride =
        sext_stride(32'(stride_q[fb_idx[l]]), SW);
      fb_ent[l].conf   = 32'(conf_q[fb_idx[l]]);
      fb_hit[l]   = fb_ent[l].valid &&
                    fb_ent[l].tag == 32'(fb_tag[l]);
      fb_d[l]     = fb_actual_i[l] - fb_ent[l].last;
      fb_match[l] = fb_hit[l] &&
                    fb_d[l] == fb_ent[l].stride;
    end
  end

  stride_vp_conflict #(
    .P_NUM_PRED    (P_NUM_PRED),
    .P_INDEX_WIDTH (IW)
  ) u_conflict (
    .valid_i     (fb_valid_i),
    .idx_i       (fb_idx),
    .match_i     (fb_match),
    .we_o        (fb_we),
    .all_match_o (fb_all_match)
  );

  // Miss or oversized delta both leave stride and conf at zero.
  always_comb begin
    nw_stride = '0;
    nw_conf   = '0;
    for (int l = 0; l < P_NUM_PRED; l++) begin
      if (fb_hit[l] && stride_fits(fb_d[l], SW)) begin
        if (fb_all_match[l]) begin
          nw_stride[l] = SW'(fb_ent[l].stride);
          nw_conf[l]   = CW'(sat_inc(fb_ent[l].conf, CW));
        end else begin
          nw_stride[l] = fb_d[l][SW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      for (int l = 0; l < P_NUM_PRED; l++)
        if (fb_we[l])
          valid_q[fb_idx[l]] <= 1'b1;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < P_NUM_PRED; l++) begin
      if (fb_we[l]) begin
        tag_q[fb_idx[l]]    <= fb_tag[l];
        last_q[fb_idx[l]]   <= fb_actual_i[l];
        stride_q[fb_idx[l]] <= nw_stride[l];
        conf_q[fb_idx[l]]   <= nw_conf[l];
      end
    end
  end

endmodule

// File: tb/tb_stride_vp_top.sv
// Self-checking bench for stride_vp_top with a per-PC
// behavioural model, directed cases and random traffic.
module tb_stride_vp_top;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0][31:0] fw_pc, pred_pc, pred_result;
  logic [N-1:0][31:0] fb_pc, fb_actual;
  logic [N-1:0] fw_valid, pred_conf, pred_valid, fb_valid;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  stride_vp_top #(
    .P_STORAGE_SIZE (2048),
    .P_CONF_WIDTH   (8),
    .P_NUM_PRED     (N),
    .P_TAG_WIDTH    (8),
    .P_STRIDE_WIDTH (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fw_pc_i       (fw_pc),
    .fw_valid_i    (fw_valid),
    .pred_pc_o     (pred_pc),
    .pred_result_o (pred_result),
    .pred_conf_o   (pred_conf),
    .pred_valid_o  (pred_valid),
    .fb_pc_i       (fb_pc),
    .fb_actual_i   (fb_actual),
    .fb_valid_i    (fb_valid)
  );

  // Behavioural table: one record per index
  bit          m_v      [2048];
  int unsigned m_tag    [2048];
  bit [31:0]   m_last   [2048];
  int          m_stride [2048];
  int          m_conf   [2048];

  logic [N-1:0]       e_valid, e_conf;
  logic [N-1:0][31:0] e_pc, e_res;

  function automatic int midx(bit [31:0] pc);
    return int'((pc >> 2) % 2048);
  endfunction

  function automatic int unsigned mtag(bit [31:0] pc);
    return (pc >> 13) % 256;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2048; i++) m_v[i] = 0;
    e_valid = '0;
    e_conf  = '0;
    e_pc    = '0;
    e_res   = '0;
  endtask

  task automatic model_feedback();
    int        ix [N];
    bit        hit[N];
    bit        mt [N];
    bit [31:0] d  [N];
    for (int l = 0; l < N; l++) begin
      ix[l]  = midx(fb_pc[l]);
      hit[l] = fb_valid[l] && m_v[ix[l]] &&
               m_tag[ix[l]] == mtag(fb_pc[l]);
      d[l]   = fb_actual[l] - m_last[ix[l]];
      mt[l]  = hit[l] && $signed(d[l]) == m_stride[ix[l]];
    end
    for (int l = 0; l < N; l++) begin
      bit win, all;
      int sd, i;
      if (!fb_valid[l]) continue;
      win = 1;
      all = 1;
      for (int j = 0; j < N; j++)
        if (fb_valid[j] && ix[j] == ix[l]) begin
          if (j > l) win = 0;
          if (j <= l && !mt[j]) all = 0;
        end
      if (!win) continue;
      i  = ix[l];
      sd = $signed(d[l]);
      if (!hit[l]) begin
        m_v[i] = 1;
        m_tag[i] = mtag(fb_pc[l]);
        m_stride[i] = 0;
        m_conf[i] = 0;
      end else if (sd < -32768 || sd > 32767) begin
        m_stride[i] = 0;
        m_conf[i] = 0;
      end else if (all) begin
        m_conf[i] = (m_conf[i] >= 255) ? 255 : m_conf[i] + 1;
      end else begin
        m_stride[i] = sd;
        m_conf[i] = 0;
      end
      m_last[i] = fb_actual[l];
    end
  endtask

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      for (int l = 0; l < N; l++) begin
        int i;
        i = midx(fw_pc[l]);
        e_valid[l] = fw_valid[l];
        e_pc[l]    = fw_pc[l];
        if (m_v[i] && m_tag[i] == mtag(fw_pc[l])) begin
          e_res[l]  = m_last[i] + 32'(m_stride[i]);
          e_conf[l] = m_conf[i] >= 128;
        end else begin
          e_res[l]  = '0;
          e_conf[l] = 1'b0;
        end
      end
      model_feedback();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int l = 0; l < N; l++) begin
        chk($sformatf("lane%0d pred_valid", l),
            32'(pred_valid[l]), 32'(e_valid[l]));
        chk($sformatf("lane%0d pred_pc", l),
            pred_pc[l], e_pc[l]);
        if (e_valid[l]) begin
          chk($sformatf("lane%0d pred_result", l),
              pred_result[l], e_res[l]);
          chk($sformatf("lane%0d pred_conf", l),
              32'(pred_conf[l]), 32'(e_conf[l]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fwd1(input logic [31:0] pc);
    fw_pc[0]    = pc;
    fw_valid    = 2'b01;
    tick();
    fw_valid    = 2'b00;
  endtask

  task automatic fb1(input logic [31:0] pc,
                     input logic [31:0] act);
    fb_pc[0]     = pc;
    fb_actual[0] = act;
    fb_valid     = 2'b01;
    tick();
    fb_valid     = 2'b00;
  endtask

  task automatic fb2(input logic [31:0] a0,
                     input logic [31:0] a1,
                     input logic [31:0] pc);
    fb_pc[0]     = pc;
    fb_pc[1]     = pc;
    fb_actual[0] = a0;
    fb_actual[1] = a1;
    fb_valid     = 2'b11;
    tick();
    fb_valid     = 2'b00;
  endtask

  logic [31:0] pool [8] = '{
    32'h100, 32'h104, 32'h2100, 32'h400,
    32'h4400, 32'h8, 32'h1000, 32'h10
  };
  bit [31:0] g_last   [8];
  int        g_stride [8];

  initial begin
    rst       = 1'b1;
    fw_valid  = '0;
    fb_valid  = '0;
    fw_pc     = '0;
    fb_pc     = '0;
    fb_actual = '0;
    e_valid   = '0;
    e_conf    = '0;
    e_pc      = '0;
    e_res     = '0;
    repeat (2) @(negedge clk);
    chk("reset pred_valid", 32'(pred_valid), 0);
    chk("reset pred_conf", 32'(pred_conf), 0);
    chk("reset pred_result", pred_result[0], 0);
    chk("reset pred_pc", pred_pc[1], 0);
    rst    = 1'b0;
    chk_en = 1;

    fwd1(32'h100);
    chk("cold valid", 32'(pred_valid[0]), 1);
    chk("cold conf", 32'(pred_conf[0]), 0);
    chk("cold result", pred_result[0], 0);

    for (int k = 0; k < 130; k++) fb1(32'h100, 10 + 4 * k);
    chk("model conf 128", m_conf[midx(32'h100)], 128);
    fwd1(32'h100);
    chk("trained result", pred_result[0], 530);
    chk("trained conf", 32'(pred_conf[0]), 1);

    for (int k = 130; k < 300; k++) fb1(32'h100, 10 + 4 * k);
    chk("model conf sat", m_conf[midx(32'h100)], 255);
    fwd1(32'h100);
    chk("sat result", pred_result[0], 1210);
    chk("sat conf", 32'(pred_conf[0]), 1);

    fb1(32'h100, 1306);
    chk("model stride 100", m_stride[midx(32'h100)], 100);
    fwd1(32'h100);
    chk("restride result", pred_result[0], 1406);
    chk("restride conf", 32'(pred_conf[0]), 0);

    fwd1(32'h2100);
    chk("alias result", pred_result[0], 0);
    chk("alias conf", 32'(pred_conf[0]), 0);
    fb1(32'h2100, 77);
    chk("realloc stride", m_stride[midx(32'h2100)], 0);
    fwd1(32'h2100);
    chk("realloc result", pred_result[0], 77);
    fwd1(32'h100);
    chk("evicted result", pred_result[0], 0);

    fb1(32'h200, 0);
    fb1(32'h200, 8);
    fb1(32'h200, 16);
    fb1(32'h200, 24);
    fb2(32, 32, 32'h200);
    chk("dual match conf", m_conf[midx(32'h200)], 3);
    fwd1(32'h200);
    chk("dual match result", pred_result[0], 40);
    fb2(99, 40, 32'h200);
    chk("dual mismatch conf", m_conf[midx(32'h200)], 0);
    fwd1(32'h200);
    chk("dual mismatch result", pred_result[0], 48);

    fw_pc[0]     = 32'h200;
    fw_pc[1]     = 32'h200;
    fw_valid     = 2'b11;
    fb_pc[0]     = 32'h300;
    fb_actual[0] = 5;
    fb_valid     = 2'b01;
    @(posedge clk);
    #2;
    chk("pre-reset valid", 32'(pred_valid), 3);
    rst = 1'b1;
    #1;
    chk("async drop valid", 32'(pred_valid), 0);
    @(negedge clk);
    tick();
    rst      = 1'b0;
    fw_valid = '0;
    fb_valid = '0;
    fwd1(32'h300);
    chk("post-reset 300", pred_result[0], 0);
    fwd1(32'h200);
    chk("post-reset 200", pred_result[0], 0);

    for (int p = 0; p < 8; p++) begin
      g_last[p]   = $urandom;
      g_stride[p] = int'($urandom_range(0, 16)) - 8;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int l = 0; l < N; l++) begin
        int p;
        fw_valid[l] = 1'($urandom_range(0, 1));
        fw_pc[l]    = pool[$urandom_range(0, 7)];
        fb_valid[l] = 1'($urandom_range(0, 1));
        p = int'($urandom_range(0, 7));
        if ($urandom_range(0, 31) == 0)
          g_stride[p] = ($urandom_range(0, 7) == 0) ?
                        int'($urandom) :
                        int'($urandom_range(0, 64)) - 32;
        g_last[p]    = g_last[p] + 32'(g_stride[p]);
        fb_pc[l]     = pool[p];
        fb_actual[l] = g_last[p];
      end
      tick();
    end
    fw_valid = '0;
    fb_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
